// File: rtl/bram18k_sdp_fifo_ctrl.sv
// FWFT FIFO controller wrapped around an 18x1024 simple-dual-port block RAM.
// Owns both RAM pointers and hides the 1-cycle RAM read latency behind a 2-entry prefetch buffer.
module bram18k_sdp_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH   = 18,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned BE_WIDTH     = 2,
  parameter int unsigned AFULL_THRESH = 1020
) (
  input  logic                  clock0,
  input  logic                  reset0,
  input  logic                  CLEAR_i,
  input  logic                  PUSH_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  output logic                  FULL_o,
  output logic                  ALMOST_FULL_o,
  input  logic                  POP_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  RVALID_o,
  output logic [ADDR_WIDTH+1:0] COUNT_o,
  output logic                  OVERFLOW_o,
  output logic                  UNDERFLOW_o,
  output logic                  RAM_WEN_o,
  output logic [BE_WIDTH-1:0]   RAM_WR_BE_o,
  output logic [ADDR_WIDTH-1:0] RAM_WR_ADDR_o,
  output logic [DATA_WIDTH-1:0] RAM_WDATA_o,
  output logic                  RAM_REN_o,
  output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR_o,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA_i
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned NW    = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [CW-1:0]         ram_cnt;
  logic                  inflight;
  logic [1:0]            buf_cnt, buf_cnt_n;
  logic [DATA_WIDTH-1:0] buf0, buf1, buf0_n, buf1_n;
  logic                  overflow, underflow;
  logic                  push_acc, pop_acc, ren;
  logic [2:0]            occ_after_pop;
  logic [1:0]            tail;

  assign FULL_o        = (ram_cnt == CW'(DEPTH));
  assign ALMOST_FULL_o = (ram_cnt >= CW'(AFULL_THRESH));
  assign RVALID_o      = (buf_cnt != 2'd0);
  assign RDATA_o       = buf0;
  assign COUNT_o       = NW'(ram_cnt) + NW'(inflight) + NW'(buf_cnt);
  assign OVERFLOW_o    = overflow;
  assign UNDERFLOW_o   = underflow;

  assign push_acc = PUSH_i & ~FULL_o & ~CLEAR_i;
  assign pop_acc  = POP_i & RVALID_o & ~CLEAR_i;

  // Issue a read only if the buffer can absorb it alongside anything already in flight.
  assign occ_after_pop = 3'(buf_cnt) + 3'(inflight) - 3'(pop_acc);
  assign ren           = ~CLEAR_i & (ram_cnt != '0) & (occ_after_pop < 3'd2);

  assign RAM_WEN_o     = push_acc;
  assign RAM_WR_BE_o   = '1;
  assign RAM_WR_ADDR_o = wptr;
  assign RAM_WDATA_o   = WDATA_i;
  assign RAM_REN_o     = ren;
  assign RAM_RD_ADDR_o = rptr;

  // Buffer next state: shift on pop, then land returning RAM data at the tail.
  always_comb begin
    buf0_n    = buf0;
    buf1_n    = buf1;
    tail      = buf_cnt - 2'(pop_acc);
    buf_cnt_n = buf_cnt - 2'(pop_acc) + 2'(inflight);
    if (pop_acc) buf0_n = buf1;
    if (inflight) begin
      if (tail == 2'd0) buf0_n = RAM_RDATA_i;
      else              buf1_n = RAM_RDATA_i;
    end
  end

  always_ff @(posedge clock0 or posedge reset0) begin
    if (reset0) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      inflight  <= 1'b0;
      buf_cnt   <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (CLEAR_i) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      inflight  <= 1'b0;
      buf_cnt   <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wptr <= wptr + ADDR_WIDTH'(1);
      if (ren)      rptr <= rptr + ADDR_WIDTH'(1);
      ram_cnt   <= ram_cnt + CW'(push_acc) - CW'(ren);
      inflight  <= ren;
      buf_cnt   <= buf_cnt_n;
      buf0      <= buf0_n;
      buf1      <= buf1_n;
      overflow  <= overflow | (PUSH_i & FULL_o);
      underflow <= underflow | (POP_i & ~RVALID_o);
    end
  end

endmodule

// File: tb/tb_bram18k_sdp_fifo_ctrl.sv
// Randomized bench for bram18k_sdp_fifo_ctrl with a behavioural RAM and a queue-based reference model.
module tb_bram18k_sdp_fifo_ctrl;

  localparam int DEPTH = 1024;
  localparam int AFT   = 1020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [17:0] wdata = '0;
  logic        full, afull, rvalid, ovf, unf, ram_wen, ram_ren;
  logic [17:0] rdata, ram_wdata, ram_rdata;
  logic [11:0] count;
  logic [1:0]  ram_be;
  logic [9:0]  ram_waddr, ram_raddr;

  logic [17:0] mem [DEPTH];

  always #5 clk = ~clk;

  bram18k_sdp_fifo_ctrl dut (
    .clock0(clk), .reset0(rst), .CLEAR_i(clear), .PUSH_i(push), .WDATA_i(wdata),
    .FULL_o(full), .ALMOST_FULL_o(afull), .POP_i(pop), .RDATA_o(rdata),
    .RVALID_o(rvalid), .COUNT_o(count), .OVERFLOW_o(ovf), .UNDERFLOW_o(unf),
    .RAM_WEN_o(ram_wen), .RAM_WR_BE_o(ram_be), .RAM_WR_ADDR_o(ram_waddr),
    .RAM_WDATA_o(ram_wdata), .RAM_REN_o(ram_ren), .RAM_RD_ADDR_o(ram_raddr),
    .RAM_RDATA_i(ram_rdata)
  );

  // Behavioural simple-dual-port RAM with registered read.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: all stored words in order, split into RAM / in-flight / buffer occupancy.
  logic [17:0] q[$];
  int m_ram, m_fly, m_buf, m_wp, m_rp;
  bit m_ovf, m_unf;

  task automatic model_reset();
    q.delete();
    m_ram = 0; m_fly = 0; m_buf = 0; m_wp = 0; m_rp = 0;
    m_ovf = 0; m_unf = 0;
  endtask

  task automatic step(input bit c, input bit pu, input bit po, input logic [17:0] d);
    bit pa, pp, rd;
    clear = c; push = pu; pop = po; wdata = d;
    @(negedge clk);
    pa = !c && pu && (m_ram != DEPTH);
    pp = !c && po && (m_buf != 0);
    rd = !c && (m_ram != 0) && ((m_buf + m_fly - int'(pp)) < 2);
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(m_ram == DEPTH));
    chk("afull", 32'(afull), 32'(m_ram >= AFT));
    chk("rvalid", 32'(rvalid), 32'(m_buf != 0));
    if (m_buf != 0) chk("rdata", 32'(rdata), 32'(q[0]));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("unf", 32'(unf), 32'(m_unf));
    chk("wen", 32'(ram_wen), 32'(pa));
    chk("ren", 32'(ram_ren), 32'(rd));
    chk("wbe", 32'(ram_be), 32'd3);
    if (pa) chk("waddr", 32'(ram_waddr), 32'(m_wp));
    if (rd) chk("raddr", 32'(ram_raddr), 32'(m_rp));
    if (c) model_reset();
    else begin
      if (pu && m_ram == DEPTH) m_ovf = 1;
      if (po && m_buf == 0) m_unf = 1;
      if (pa) begin q.push_back(d); m_wp = (m_wp + 1) % DEPTH; end
      if (pp) void'(q.pop_front());
      if (rd) m_rp = (m_rp + 1) % DEPTH;
      m_ram = m_ram + int'(pa) - int'(rd);
      m_buf = m_buf - int'(pp) + m_fly;
      m_fly = int'(rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear = 0; push = 0; pop = 0;
    rst = 1'b1;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    chk("rst_ren", 32'(ram_ren), 32'd0);
    chk("rst_wen", 32'(ram_wen), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  task automatic rand_run(input int n, input int clr_pct);
    for (int i = 0; i < n; i++)
      step($urandom_range(99) < 32'(clr_pct), $urandom_range(1) == 1,
           $urandom_range(1) == 1, 18'($urandom));
  endtask

  logic [17:0] lfsr;

  initial begin
    #1;
    do_reset();
    idle(2);
    step(0, 1, 0, 18'h00001);
    idle(3);
    rand_run(200, 0);
    #2 do_reset();
    step(0, 1, 0, 18'h00001);
    idle(3);
    // Fill past full with index data, then drain everything.
    step(1, 0, 0, '0);
    for (int i = 0; i < 1027; i++) step(0, 1, 0, 18'(i));
    idle(3);
    for (int i = 0; i < 1030; i++) step(0, 0, 1, '0);
    // Sustained push+pop streaming with LFSR data.
    step(1, 0, 0, '0);
    lfsr = 18'h2F3A1;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, lfsr);
      lfsr = {lfsr[16:0], lfsr[17] ^ lfsr[10]};
    end
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      step(0, 1, 1, lfsr);
      lfsr = {lfsr[16:0], lfsr[17] ^ lfsr[10]};
    end
    // Almost-full threshold crossing and release.
    step(1, 0, 0, '0);
    for (int i = 0; i < 1021; i++) step(0, 1, 0, 18'($urandom));
    idle(3);
    step(0, 1, 0, 18'h1);
    idle(2);
    step(0, 0, 1, '0);
    idle(3);
    // Underflow then clear.
    step(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, '0);
    step(1, 0, 0, '0);
    idle(2);
    // Clear while a RAM read is in flight.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 18'(16 + i));
    idle(4);
    step(0, 0, 1, '0);
    step(1, 0, 1, '0);
    idle(2);
    step(0, 1, 0, 18'h2AAAA);
    idle(4);
    step(0, 0, 1, '0);
    rand_run(600, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
